fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Front-end fetch controller for the superscalar core. It owns the program counter and drives the eight read-address ports of the 8-port instruction memory each cycle. Invalid slots receive the memory's "no-read" sentinel 32'hffff, which makes the memory return 32'b0. It presents up to eight instructions per cycle to the decoder through a valid/ready handshake, advances by the number the decoder consumed, and handles branch redirects, end-of-program and halt.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- MEM_BYTES, 1028, byte size of instruction memory (257 words); addresses >= MEM_BYTES are out of range.
- INVALID_ADDR, 32'hffff, sentinel driven on unused address ports.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a1 .. a8  out  32 each  read addresses to instruction memory ports 1..8.
- slot_valid  out  8  bit k-1 set when a(k) carries a real address.
- fetch_valid  out  1  bundle on the memory read data is offered to the decoder.
- dec_ready  in  1  decoder accepts the bundle this cycle.
- consume_cnt  in  4  instructions taken from slot 1 upward (0..8), sampled only on handshake.
- redirect  in  1  branch/jump resolved; reload PC.
- redirect_pc  in  32  target byte address; bits [1:0] are ignored (forced 0).
- halt  in  1  stop fetching (held until redirect or reset).
- done  out  1  sequencer is in DONE state.
- fetched_cnt  out  32  total instructions consumed since reset (wraps at 2^32).

## Operation
- Registered state: 2-bit FSM, 32-bit pc, fetched_cnt. All outputs are combinational from these registers only, with no input-to-output paths.
- FSM states:
  - BOOT: after reset. Always goes to FETCH on the next edge. If redirect is asserted in that cycle, pc loads redirect_pc.
  - FETCH: offers the bundle.
  - DONE: reached when halt is asserted, or when slot 1 is out of range (pc >= MEM_BYTES). Leaves only on redirect (to FETCH) or reset.
- Slot k (k = 1..8):
  - Address is pc + 4(k-1), computed in 33 bits.
  - The slot is valid iff state = FETCH, there is no 33-bit carry, and the address < MEM_BYTES.
  - Valid slot: a(k) = that address. Invalid slot: a(k) = INVALID_ADDR.
  - Valid slots are always contiguous from slot 1.
- fetch_valid = (state == FETCH) and slot_valid[0].
- Handshake occurs when fetch_valid and dec_ready are both high:
  - n = min(consume_cnt, popcount(slot_valid)).
  - pc <= pc + 4n; fetched_cnt <= fetched_cnt + n.
  - n = 0 leaves pc unchanged.
- Without a handshake, pc and all outputs hold.
- Priority on the same edge, highest first:
  1. redirect: pc <= {redirect_pc[31:2],2'b00}; state <= FETCH. Any concurrent consume is discarded and fetched_cnt is not incremented.
  2. halt: state <= DONE; pc holds.
  3. Handshake advance.
  4. Out-of-range check. Evaluated on the post-advance pc: if the new pc >= MEM_BYTES, state <= DONE.
- In FETCH with pc >= MEM_BYTES (for example after a redirect beyond memory), the sequencer moves to DONE on the next edge. fetch_valid stays 0 during that cycle.

## Timing
- Reset (rst_n low, asynchronous):
  - state = BOOT, pc = RESET_PC, fetched_cnt = 0.
  - a1..a8 = 32'hffff, slot_valid = 0, fetch_valid = 0, done = 0.
- First edge after rst_n rises: BOOT→FETCH. fetch_valid is high in the 2nd cycle after release.
- Address-to-data latency is zero: the memory is combinational, so data for a bundle is valid in the same cycle as a1..a8.
- Consume to next bundle: 1 cycle, i.e. a sustained throughput of 8 instructions per cycle with consume_cnt = 8.
- Redirect: the target bundle is offered in the cycle after redirect is sampled. There is no bubble beyond that one edge.
- halt: done rises the cycle after halt is sampled; all slots are invalid from that cycle.
- Reset asserted mid-bundle: outputs go to reset values immediately, without waiting for a clock edge. No partial consume is retained.

## Test plan
- Reset/boot: hold rst_n low 3 cycles, then release. Required: a1..a8 = 32'hffff and fetch_valid = 0 during reset and the BOOT cycle. Cycle 2: a1 = 0, a8 = 28 (0x1C), slot_valid = 8'hFF.
- Linear stream:
  - dec_ready = 1, consume_cnt = 8 for 4 cycles. Required: a1 = 0, 32, 64, 96; fetched_cnt = 32.
  - Then consume_cnt = 3. Required: next a1 = 140.
  - Then dec_ready = 0 for 2 cycles. Required: pc holds.
- End of memory: redirect to 1012. Required:
  - a1..a5 = 1012..1028 minus the out-of-range slot, giving slot_valid = 8'h0F (1012, 1016, 1020, 1024 valid); a5..a8 = 32'hffff.
  - consume_cnt = 8. Required: n clamps to 4, pc = 1028, done = 1 next cycle, fetched_cnt increments by 4.
- Redirect vs consume: redirect = 1, redirect_pc = 32'h43, consume_cnt = 5 with handshake on the same edge. Required: next a1 = 0x40, fetched_cnt unchanged.
- Halt and restart:
  - halt for 1 cycle. Required: done = 1, all slots invalid, pc preserved.
  - redirect to 0x80. Required: FETCH with a1 = 0x80 next cycle.
- Overflow and async reset:
  - redirect_pc = 32'hFFFF_FFF8. Required: pc >= MEM_BYTES, so fetch_valid = 0 and DONE next cycle.
  - Pulse rst_n low between edges while in FETCH. Required: outputs return to reset values immediately.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch front end: owns the PC, drives eight instruction-memory read ports
// and hands up to eight instructions per cycle to the decoder.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned MEM_BYTES    = 1028,
  parameter logic [31:0] INVALID_ADDR = 32'h0000_ffff
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] a1,
  output logic [31:0] a2,
  output logic [31:0] a3,
  output logic [31:0] a4,
  output logic [31:0] a5,
  output logic [31:0] a6,
  output logic [31:0] a7,
  output logic [31:0] a8,
  output logic [7:0]  slot_valid,
  output logic        fetch_valid,
  input  logic        dec_ready,
  input  logic [3:0]  consume_cnt,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        done,
  output logic [31:0] fetched_cnt
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [32:0] LIMIT = 33'(MEM_BYTES);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_fetched;

  logic [32:0] w_addr [8];
  logic [31:0] w_a    [8];
  logic [7:0]  w_sv;
  logic [3:0]  w_avail;
  logic [3:0]  w_n;
  logic        w_hs;
  logic [32:0] w_nxt;
  logic        w_oor;
  logic [31:0] w_tgt;

  always_comb begin
    w_sv    = '0;
    w_avail = '0;
    for (int k = 0; k < 8; k++) begin
      w_addr[k] = {1'b0, r_pc} + 33'(4 * k);
      w_sv[k]   = (r_state == S_FETCH) && !w_addr[k][32]
                  && (w_addr[k] < LIMIT);
      w_a[k]    = w_sv[k] ? w_addr[k][31:0] : INVALID_ADDR;
      w_avail   = w_avail + {3'b0, w_sv[k]};
    end
    w_n   = (consume_cnt < w_avail) ? consume_cnt : w_avail;
    w_hs  = w_sv[0] && dec_ready;
    // out-of-range test uses the post-advance PC in 33 bits
    w_nxt = w_hs ? ({1'b0, r_pc} + {27'b0, w_n, 2'b00})
                 : {1'b0, r_pc};
    w_oor = (w_nxt >= LIMIT);
    w_tgt = {redirect_pc[31:2], 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_BOOT;
      r_pc      <= RESET_PC;
      r_fetched <= '0;
    end else begin
      unique case (r_state)
        S_BOOT: begin
          r_state <= S_FETCH;
          if (redirect) r_pc <= w_tgt;
        end
        S_FETCH: begin
          if (redirect) begin
            r_pc <= w_tgt;
          end else if (halt) begin
            r_state <= S_DONE;
          end else begin
            r_pc <= w_nxt[31:0];
            if (w_hs) r_fetched <= r_fetched + {28'b0, w_n};
            if (w_oor) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (redirect) begin
            r_pc    <= w_tgt;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

  assign a1          = w_a[0];
  assign a2          = w_a[1];
  assign a3          = w_a[2];
  assign a4          = w_a[3];
  assign a5          = w_a[4];
  assign a6          = w_a[5];
  assign a7          = w_a[6];
  assign a8          = w_a[7];
  assign slot_valid  = w_sv;
  assign fetch_valid = w_sv[0];
  assign done        = (r_state == S_DONE);
  assign fetched_cnt = r_fetched;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: expectations queued at drive time,
// popped and compared on the falling edge after the DUT updates.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a [8];
  logic [7:0]  slot_valid;
  logic        fetch_valid;
  logic        dec_ready = 1'b0;
  logic [3:0]  consume_cnt = 4'd0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;
  logic        done;
  logic [31:0] fetched_cnt;

  typedef struct {
    string       tag;
    logic [31:0] a1;
    logic [7:0]  sv;
    logic        fv;
    logic        dn;
    logic [31:0] fc;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .a1(a[0]), .a2(a[1]), .a3(a[2]), .a4(a[3]),
    .a5(a[4]), .a6(a[5]), .a7(a[6]), .a8(a[7]),
    .slot_valid(slot_valid), .fetch_valid(fetch_valid),
    .dec_ready(dec_ready), .consume_cnt(consume_cnt),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .done(done), .fetched_cnt(fetched_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    total++;
    assert (obs === want) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, want);
  endtask

  task automatic push(input string tag, input logic [31:0] a1,
                      input logic [7:0] sv, input logic fv,
                      input logic dn, input logic [31:0] fc);
    exp_t e;
    e.tag = tag; e.a1 = a1; e.sv = sv;
    e.fv = fv; e.dn = dn; e.fc = fc;
    q.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    logic [31:0] wa;
    total++;
    assert (q.size() > 0) passed++;
    else $error("FAIL scoreboard_empty: got %0d want >0", q.size());
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.tag, ".sv"}, {24'b0, slot_valid}, {24'b0, e.sv});
      chk({e.tag, ".fv"}, {31'b0, fetch_valid}, {31'b0, e.fv});
      chk({e.tag, ".done"}, {31'b0, done}, {31'b0, e.dn});
      chk({e.tag, ".fc"}, fetched_cnt, e.fc);
      for (int k = 0; k < 8; k++) begin
        wa = e.sv[k] ? e.a1 + 32'(4 * k) : 32'h0000_ffff;
        chk($sformatf("%s.a%0d", e.tag, k + 1), a[k], wa);
      end
    end
  endtask

  task automatic step(input string tag, input logic rdy,
                      input logic [3:0] cc, input logic rd,
                      input logic [31:0] rpc, input logic hl,
                      input logic [31:0] a1, input logic [7:0] sv,
                      input logic fv, input logic dn,
                      input logic [31:0] fc);
    dec_ready = rdy; consume_cnt = cc;
    redirect = rd; redirect_pc = rpc; halt = hl;
    push(tag, a1, sv, fv, dn, fc);
    @(posedge clk);
    @(negedge clk);
    pop_cmp();
  endtask

  localparam logic [31:0] INV = 32'h0000_ffff;

  initial begin
    repeat (3) begin
      @(negedge clk);
      push("reset", INV, 8'h00, 1'b0, 1'b0, 32'd0);
      pop_cmp();
    end
    rst_n = 1'b1;
    push("boot", INV, 8'h00, 1'b0, 1'b0, 32'd0);
    pop_cmp();
    step("fetch0", 0, 0, 0, 0, 0, 32'd0, 8'hFF, 1, 0, 32'd0);
    step("lin1", 1, 8, 0, 0, 0, 32'd32, 8'hFF, 1, 0, 32'd8);
    step("lin2", 1, 8, 0, 0, 0, 32'd64, 8'hFF, 1, 0, 32'd16);
    step("lin3", 1, 8, 0, 0, 0, 32'd96, 8'hFF, 1, 0, 32'd24);
    step("lin4", 1, 8, 0, 0, 0, 32'd128, 8'hFF, 1, 0, 32'd32);
    step("cons3", 1, 3, 0, 0, 0, 32'd140, 8'hFF, 1, 0, 32'd35);
    step("stall1", 0, 8, 0, 0, 0, 32'd140, 8'hFF, 1, 0, 32'd35);
    step("stall2", 0, 8, 0, 0, 0, 32'd140, 8'hFF, 1, 0, 32'd35);
    step("eom", 0, 0, 1, 32'd1012, 0, 32'd1012, 8'h0F, 1, 0, 32'd35);
    step("clamp", 1, 8, 0, 0, 0, INV, 8'h00, 0, 1, 32'd39);
    chk("clamp.pc", dut.r_pc, 32'd1028);
    step("rd20", 0, 0, 1, 32'h20, 0, 32'h20, 8'hFF, 1, 0, 32'd39);
    step("rdcons", 1, 5, 1, 32'h43, 0, 32'h40, 8'hFF, 1, 0, 32'd39);
    step("halt", 1, 8, 0, 0, 1, INV, 8'h00, 0, 1, 32'd39);
    chk("halt.pc", dut.r_pc, 32'h40);
    step("hold", 1, 8, 0, 0, 0, INV, 8'h00, 0, 1, 32'd39);
    step("restart", 0, 0, 1, 32'h80, 0, 32'h80, 8'hFF, 1, 0, 32'd39);
    step("ovf", 0, 0, 1, 32'hFFFF_FFF8, 0, INV, 8'h00, 0, 0, 32'd39);
    step("ovfdone", 1, 8, 0, 0, 0, INV, 8'h00, 0, 1, 32'd39);
    step("back", 0, 0, 1, 32'h0, 0, 32'h0, 8'hFF, 1, 0, 32'd39);
    dec_ready = 1'b1; consume_cnt = 4'd8; redirect = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    push("async", INV, 8'h00, 1'b0, 1'b0, 32'd0);
    pop_cmp();
    chk("async.pc", dut.r_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dec_ready = 1'b0;
    step("reboot", 0, 0, 0, 0, 0, 32'd0, 8'hFF, 1, 0, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
